// File: rtl/key_filter_multi_if.sv
// -----------------------------------------------------------------------------
// key_filter_multi_if
// Bundles the raw key inputs and the filtered key outputs of key_filter_multi.
//
// Parameters:
//   NUM_KEYS    number of key channels carried on every vector
//
// Signals:
//   btn         raw, asynchronous key levels (driven by the key side)
//   key_out     debounced level per channel, 1 = pressed
//   key_press   one-cycle pulse when a channel becomes pressed
//   key_release one-cycle pulse when a channel becomes released
//   key_repeat  one-cycle auto-repeat pulse while a channel is held
//
// Modports:
//   master      the key side / consumer: drives btn, observes the filter outputs
//   slave       the filter itself: samples btn, drives the outputs
// -----------------------------------------------------------------------------
interface key_filter_multi_if #(
  parameter int NUM_KEYS = 6
);
  logic [NUM_KEYS-1:0] btn;
  logic [NUM_KEYS-1:0] key_out;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output btn,
    input  key_out,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  btn,
    output key_out,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

// File: rtl/key_filter_multi.sv
// -----------------------------------------------------------------------------
// key_filter_multi
// Multi-channel key debouncer. Every channel synchronizes its raw key input,
// normalizes it so that 1 means pressed, and only accepts a new level after it
// has been stable for DEBOUNCE_CYCLES consecutive cycles. Accepted changes
// produce one-cycle press / release pulses. Channels are fully independent.
//
// Optional feature (macro KEY_REPEAT_EN):
//   When defined, a held key emits key_repeat pulses: the first one
//   REPEAT_DELAY cycles after key_press, then one every REPEAT_PERIOD cycles.
//   When undefined, key_repeat is tied to 0 and no repeat logic exists.
//
// Parameters:
//   NUM_KEYS         number of channels (1..32)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a new level (>= 2)
//   ACTIVE_LEVEL     raw btn level meaning "pressed" (1 or 0)
//   REPEAT_DELAY     press-to-first-repeat distance in cycles (repeat only)
//   REPEAT_PERIOD    distance between later repeat pulses (repeat only)
//
// Ports:
//   clk   system clock, everything on its rising edge
//   rst   synchronous, active-high reset
//   bus   key_filter_multi_if slave modport (btn in, key_* out)
// -----------------------------------------------------------------------------
module key_filter_multi #(
  parameter int NUM_KEYS        = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LEVEL    = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  key_filter_multi_if.slave  bus
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  // Counter is just wide enough for DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] btn_norm;
  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync_lvl;
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] rel_pulse;
  logic [NUM_KEYS-1:0] accept;
  logic [CNT_W-1:0]    cnt   [NUM_KEYS];
  state_t              state [NUM_KEYS];

  // Normalizing before the first flop is timing-equivalent to normalizing
  // after the synchronizer, and lets both flops reset to "released" (0)
  // regardless of the key polarity.
  assign btn_norm = (ACTIVE_LEVEL != 0) ? bus.btn : ~bus.btn;

  // A channel accepts its new level on the edge where the counter has reached
  // its last value and the synchronized level still disagrees with key_out.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      accept[i] = (state[i] == COUNT) && (sync_lvl[i] != key_lvl[i]) &&
                  (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta   <= '0;
      sync_lvl    <= '0;
      key_lvl     <= '0;
      press_pulse <= '0;
      rel_pulse   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i]   <= '0;
        state[i] <= IDLE;
      end
    end else begin
      sync_meta   <= btn_norm;
      sync_lvl    <= sync_meta;
      press_pulse <= '0;
      rel_pulse   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        case (state[i])
          IDLE: begin
            if (sync_lvl[i] != key_lvl[i]) begin
              state[i] <= COUNT;
              cnt[i]   <= '0;
            end
          end
          COUNT: begin
            if (sync_lvl[i] == key_lvl[i]) begin
              // Level bounced back before acceptance: drop the attempt.
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (accept[i]) begin
              // Pulses are registered on the same edge as the new level so
              // they line up with the first cycle key_out shows it.
              state[i]       <= IDLE;
              cnt[i]         <= '0;
              key_lvl[i]     <= ~key_lvl[i];
              press_pulse[i] <= ~key_lvl[i];
              rel_pulse[i]   <= key_lvl[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.key_out     = key_lvl;
  assign bus.key_press   = press_pulse;
  assign bus.key_release = rel_pulse;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                          : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]    rep_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] rep_first;
  logic [NUM_KEYS-1:0] rep_pulse;

  // Repeat timer per channel. It only runs while the key is held and is not
  // changing on this edge, so the press edge starts it from zero and the
  // release edge kills it without a final pulse. rep_first selects the long
  // initial delay versus the shorter steady-state period.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_pulse <= '0;
      rep_first <= '1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        rep_cnt[i] <= '0;
      end
    end else begin
      rep_pulse <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (accept[i] || !key_lvl[i]) begin
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b1;
        end else if (rep_cnt[i] == (rep_first[i] ? DELAY_LAST : PERIOD_LAST)) begin
          rep_pulse[i] <= 1'b1;
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b0;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end

  assign bus.key_repeat = rep_pulse;
`else
  assign bus.key_repeat = '0;
`endif

endmodule

// File: doc/key_filter_multi.md
KEY_FILTER_MULTI -- requirements
Module: key_filter_multi

Interface
REQ-001 Parameter NUM_KEYS, default 6: number of independent key channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: number of consecutive stable clock cycles required to accept a new key level, legal range >= 2.
REQ-003 Parameter ACTIVE_LEVEL, default 1: raw btn level that means "pressed"; 0 selects active-low keys.
REQ-004 Parameter REPEAT_DELAY, default 25000000: cycles from press acceptance to the first repeat pulse; used only with KEY_REPEAT_EN.
REQ-005 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses; used only with KEY_REPEAT_EN.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 btn  input  NUM_KEYS  raw asynchronous key levels.
REQ-009 key_out  output  NUM_KEYS  debounced level per channel; 1 = pressed, independent of ACTIVE_LEVEL.
REQ-010 key_press  output  NUM_KEYS  one-cycle pulse per channel when key_out goes 0->1.
REQ-011 key_release  output  NUM_KEYS  one-cycle pulse per channel when key_out goes 1->0.
REQ-012 key_repeat  output  NUM_KEYS  one-cycle auto-repeat pulse per channel.

Function
REQ-013 Each btn bit SHALL pass through a two-flop synchronizer, then be normalized so that pressed = 1 (XOR with inverse of ACTIVE_LEVEL).
REQ-014 Each channel SHALL hold its own state machine with states IDLE (synced level == key_out) and COUNT (synced level != key_out), plus a private counter sized to hold DEBOUNCE_CYCLES-1.
REQ-015 IDLE->COUNT: the synced level differs from key_out; the counter loads 0.
REQ-016 COUNT: the counter increments each cycle while the synced level still differs from key_out.
REQ-017 COUNT->IDLE (abort): the synced level equals key_out again before acceptance; the counter clears and key_out is unchanged.
REQ-018 COUNT->IDLE (accept): the counter equals DEBOUNCE_CYCLES-1 and the level still differs; key_out toggles on that edge.
REQ-019 A clean level change on btn SHALL appear on key_out exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-020 key_press / key_release SHALL assert in the same cycle key_out first shows the new level, for exactly one cycle.
REQ-021 Channels SHALL be fully independent: simultaneous events on several channels produce simultaneous, uncoupled outputs.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no change on any output.

Reset
REQ-023 With rst high at a rising edge: key_out, key_press, key_release and key_repeat = 0; all counters = 0; all states = IDLE; synchronizer flops = the normalized released level (0).
REQ-024 Reset asserted mid-COUNT SHALL abort the count with no output pulse.
REQ-025 A key already held when rst deasserts SHALL be accepted normally after DEBOUNCE_CYCLES+2 cycles and SHALL produce one key_press.

Configuration
REQ-026 With macro KEY_REPEAT_EN defined, each pressed channel SHALL run a repeat counter: the first key_repeat pulse comes REPEAT_DELAY cycles after key_press, then one pulse every REPEAT_PERIOD cycles while key_out stays 1.
REQ-027 Under KEY_REPEAT_EN, release or reset SHALL clear the repeat counter at once and emit no further repeat pulse.
REQ-028 Without KEY_REPEAT_EN, key_repeat SHALL be constant 0, no repeat logic SHALL be synthesized, and REPEAT_DELAY and REPEAT_PERIOD are ignored.

Verification (NUM_KEYS=4, DEBOUNCE_CYCLES=4, ACTIVE_LEVEL=1, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 btn[0] 0->1 held -> key_out[0]=1 and key_press[0] one-cycle pulse exactly 6 edges later; other bits stay 0.
REQ-030 btn[1] high for 3 cycles then low -> key_out[1], key_press[1] and key_release[1] remain 0 throughout.
REQ-031 btn=4'b1111 at once, held 20 cycles, then 4'b0000 -> all four presses in the same cycle, then all four releases in the same cycle.
REQ-032 rst pulsed 2 cycles after btn[2] rises, btn held -> no pulse during reset; key_press[2] 6 edges after rst falls.
REQ-033 KEY_REPEAT_EN, btn[3] held 30 cycles -> key_repeat[3] at 10, 13, 16, ... cycles after key_press[3]; none after key_release[3].
REQ-034 ACTIVE_LEVEL=0, btn idle 4'b1111, btn[0] driven low -> key_out[0]=1 after 6 edges; no press on other channels after reset.
